sincos_arbiter: RTL and testbench
=================================

# sincos_arbiter

Round-robin arbiter and sequencer that shares one non-pipelined SinCos CORDIC core among NUM_REQ requesters. Accepts a 10-bit phase per request, issues a single-cycle trigger to the core, waits for the core's valid, and returns the sin/cos result tagged with the requester ID. It sits between client blocks and the CORDIC top and is the only driver of the core's trigger and phase inputs.

## Interface
- NUM_REQ, 4, number of requesters, legal 2..8
- TIMEOUT, 100, cycles allowed from trigger to core valid (used only with timeout compiled in)
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-high
- req_vld  in  NUM_REQ  per-requester request valid
- req_phase  in  NUM_REQ*10  packed phases; requester k uses bits [10k+9:10k]
- req_rdy  out  NUM_REQ  one-hot accept strobe
- cor_trig  out  1  core trigger, single-cycle pulse
- cor_data  out  10  phase to core
- cor_vld  in  1  core result valid
- cor_sin, cor_cos  in  13  signed Q1.11 core results
- resp_vld  out  1  single-cycle response strobe, no backpressure
- resp_id  out  $clog2(NUM_REQ)  requester index of response
- resp_sin, resp_cos  out  13  signed response data
- resp_err  out  1  timeout flag, qualified by resp_vld

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any req_vld, the round-robin grant g is the first set bit searching from ptr+1 modulo NUM_REQ. req_rdy[g]=1 combinationally in this cycle; phase and g are registered; ptr<=g; go to ISSUE. No req_vld: stay, req_rdy=0.
- ISSUE: cor_trig=1, cor_data=latched phase for exactly one cycle; clear timeout counter; go to WAIT.
- WAIT: on cor_vld, capture cor_sin/cor_cos into the response registers with err=0 and go to RESP. cor_vld outside WAIT is ignored.
- RESP: resp_vld=1 for one cycle with registered data/id/err; return to IDLE.
- req_rdy is asserted only in IDLE. A requester must hold req_vld and req_phase stable until it sees req_rdy. Deasserting req_vld before the grant withdraws the request.
- cor_data is 0 whenever cor_trig=0.
- Response data is passed through unmodified; no saturation or rescaling.

## Timing
- Reset values: state=IDLE, ptr=NUM_REQ-1 (requester 0 has first priority), req_rdy=0, cor_trig=0, cor_data=0, resp_vld=0, resp_id=0, resp_sin=0, resp_cos=0, resp_err=0.
- With acceptance at cycle T: cor_trig at T+1. If the core reports valid L cycles after trigger (cor_vld at T+1+L), resp_vld is at T+2+L.
- Minimum back-to-back period is L+3 cycles. The next grant can occur in the cycle after RESP.
- Asynchronous reset mid-operation aborts the transaction and emits no response. Any late cor_vld is ignored.
- Simultaneous requests are served in rotation. Example: after reset, all four asserted gives the grant order 0,1,2,3.

## Configuration
- SINCOS_ARB_TIMEOUT_EN defined:
  - The WAIT counter increments each cycle.
  - When the counter reaches TIMEOUT-1 without cor_vld, go to RESP with resp_err=1 and resp_sin=resp_cos=0.
  - If cor_vld coincides with the terminal count, the valid result wins and err=0.
- SINCOS_ARB_TIMEOUT_EN undefined: no counter; WAIT is exited only by cor_vld; resp_err is tied 0.

## Structure
- Package sincos_arb_pkg contains:
  - state enum: IDLE, ISSUE, WAIT, RESP
  - PHASE_W=10, DATA_W=13
  - default TIMEOUT constant
- One sub-module, rr_arbiter. Inputs: request vector, ptr. Outputs: one-hot grant and encoded index. It is purely combinational.
- The FSM, counter and registers live in sincos_arbiter.

## Test plan
- Single request: requester 2, phase 256; stub core with L=14 returns sin=2048, cos=0. Expect cor_trig at T+1 with cor_data=256, and resp_vld at T+16 with id=2, sin=2048, cos=0, err=0.
- Fairness: req_vld=4'b1111 held after reset. Expect grants 0,1,2,3,0. req_rdy is never multi-hot, and there is exactly one cor_trig per grant.
- Withdraw and skip: only requesters 1 and 3 active, ptr=1. Expect grant 3, then grant 1. Requester 0 deasserted before grant receives no req_rdy.
- Timeout (macro on, TIMEOUT=100): stub never asserts cor_vld. Expect resp_vld 101 cycles after cor_trig with err=1, sin=cos=0. A cor_vld injected 5 cycles later produces no response.
- Timeout tie: cor_vld exactly at the terminal count. Expect err=0 and the core data returned.
- Reset in WAIT: assert sys_rst_n for 2 cycles. Expect all outputs at reset values immediately (asynchronous), no resp_vld, and requester 0 granted first afterwards.

Source files
------------

// File: rtl/sincos_arb_pkg.sv
// Shared constants and FSM state type for the SinCos CORDIC request arbiter.
package sincos_arb_pkg;

  localparam int PHASE_W     = 10;
  localparam int DATA_W      = 13;
  localparam int TIMEOUT_DEF = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/sincos_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first set request searching upward from ptr+1.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  // Scan farthest-to-nearest so the requester closest after ptr overwrites the rest.
  always_comb begin
    int k;
    gnt     = '0;
    gnt_idx = '0;
    k       = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (req[k[IDX_W-1:0]]) begin
        gnt     = '0;
        gnt[k[IDX_W-1:0]] = 1'b1;
        gnt_idx = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sincos_arbiter.sv
// Shares one non-pipelined SinCos CORDIC core among NUM_REQ requesters.
// Define SINCOS_ARB_TIMEOUT_EN to add a WAIT watchdog that reports resp_err.
//
// state | meaning
// IDLE  | look for requests, grant round-robin, latch phase and id
// ISSUE | one-cycle trigger to the core with the latched phase
// WAIT  | wait for core valid (or watchdog expiry when compiled in)
// RESP  | one-cycle response strobe with registered data
module sincos_arbiter
  import sincos_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*PHASE_W-1:0]    req_phase,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic                          cor_trig,
  output logic [PHASE_W-1:0]            cor_data,
  input  logic                          cor_vld,
  input  logic signed [DATA_W-1:0]      cor_sin,
  input  logic signed [DATA_W-1:0]      cor_cos,
  output logic                          resp_vld,
  output logic [IDX_W-1:0]              resp_id,
  output logic signed [DATA_W-1:0]      resp_sin,
  output logic signed [DATA_W-1:0]      resp_cos,
  output logic                          resp_err
);

  state_t                   state_q;
  logic [IDX_W-1:0]         ptr_q;
  logic [IDX_W-1:0]         id_q;
  logic [PHASE_W-1:0]       phase_q;
  logic signed [DATA_W-1:0] sin_q;
  logic signed [DATA_W-1:0] cos_q;
  logic [NUM_REQ-1:0]       gnt;
  logic [IDX_W-1:0]         gnt_idx;
  logic [PHASE_W-1:0]       sel_phase;
  logic                     take;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req_vld),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // No accept strobe while reset is held: nothing would be captured.
  assign take      = (state_q == IDLE) && (|req_vld) && !sys_rst_n;
  assign req_rdy   = take ? gnt : '0;
  assign sel_phase = req_phase[int'(gnt_idx)*PHASE_W +: PHASE_W];

  assign cor_trig  = (state_q == ISSUE);
  assign cor_data  = cor_trig ? phase_q : '0;
  assign resp_vld  = (state_q == RESP);
  assign resp_id   = id_q;
  assign resp_sin  = sin_q;
  assign resp_cos  = cos_q;

`ifdef SINCOS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             tmo;

  assign tmo      = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign resp_err = err_q;

  // A valid on the terminal-count cycle wins over the timeout.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == WAIT) && (cor_vld || tmo)) begin
        err_q <= !cor_vld;
      end
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      id_q    <= '0;
      phase_q <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_vld) begin
            state_q <= ISSUE;
            ptr_q   <= gnt_idx;
            id_q    <= gnt_idx;
            phase_q <= sel_phase;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (cor_vld) begin
            sin_q   <= cor_sin;
            cos_q   <= cor_cos;
            state_q <= RESP;
          end
`ifdef SINCOS_ARB_TIMEOUT_EN
          else if (tmo) begin
            sin_q   <= '0;
            cos_q   <= '0;
            state_q <= RESP;
          end
`endif
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_arbiter.sv
// Randomized bench for sincos_arbiter against a cycle-scheduled transaction model.
module tb_sincos_arbiter;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TMO = 100;
  localparam int NEVER = 1 << 30;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n = 1'b1;
  logic [N-1:0]         req_vld;
  logic [N*10-1:0]      req_phase;
  logic [N-1:0]         req_rdy;
  logic                 cor_trig;
  logic [9:0]           cor_data;
  logic                 cor_vld;
  logic signed [12:0]   cor_sin, cor_cos;
  logic                 resp_vld;
  logic [IW-1:0]        resp_id;
  logic signed [12:0]   resp_sin, resp_cos;
  logic                 resp_err;

  always #5 sys_clk = ~sys_clk;

  sincos_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_vld   (req_vld),
    .req_phase (req_phase),
    .req_rdy   (req_rdy),
    .cor_trig  (cor_trig),
    .cor_data  (cor_data),
    .cor_vld   (cor_vld),
    .cor_sin   (cor_sin),
    .cor_cos   (cor_cos),
    .resp_vld  (resp_vld),
    .resp_id   (resp_id),
    .resp_sin  (resp_sin),
    .resp_cos  (resp_cos),
    .resp_err  (resp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: one outstanding transaction described by the cycles its events must occur on
  int                 cyc = 0;
  bit                 m_busy;
  int                 m_ptr, m_id;
  logic [9:0]         m_phase;
  int                 m_trig_at, m_resp_at;
  logic signed [12:0] m_sin, m_cos;
  bit                 m_err;

  // stub core and stimulus controls
  int                 core_at = -1, spur_at = -1;
  logic signed [12:0] core_sin, core_cos;
  int                 stub_lat = 0;
  bit                 stub_fix = 0, stub_never = 0, spur_en = 0;
  logic signed [12:0] fix_sin = 0, fix_cos = 0;
  logic [N-1:0]       drv_vld = '0;
  logic [N*10-1:0]    drv_phase = '0;
  logic [N-1:0]       seen_rdy;

  int                 grant_log[$];
  int                 gcyc_log[$];
  int                 last_trig_cyc, last_resp_cyc;
  int                 last_resp_id;
  logic signed [12:0] last_resp_sin, last_resp_cos;
  bit                 last_resp_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = N - 1; m_trig_at = -1; m_resp_at = -1;
    core_at = -1; spur_at = -1;
  endtask

  task automatic check_cycle();
    int g;
    int lat;
    int k;
    logic [N-1:0] exp_rdy;
    g = -1;
    if (!m_busy)
      for (int i = 1; i <= N; i++) begin
        k = (m_ptr + i) % N;
        if (g < 0 && req_vld[k]) g = k;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    seen_rdy = req_rdy;
    chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    if (g >= 0) begin
      m_busy = 1; m_ptr = g; m_id = g;
      m_phase = req_phase[g*10 +: 10];
      m_trig_at = cyc + 1; m_resp_at = NEVER;
      grant_log.push_back(g); gcyc_log.push_back(cyc);
    end
    chk("cor_trig", 32'(cor_trig), 32'(cyc == m_trig_at));
    chk("cor_data", 32'(cor_data), (cyc == m_trig_at) ? 32'(m_phase) : 32'd0);
    if (cyc == m_trig_at) begin
      last_trig_cyc = cyc;
      lat = (stub_lat != 0) ? stub_lat : int'($urandom_range(20, 1));
      core_sin = stub_fix ? fix_sin : 13'($urandom);
      core_cos = stub_fix ? fix_cos : 13'($urandom);
      core_at  = stub_never ? -1 : cyc + lat;
`ifdef SINCOS_ARB_TIMEOUT_EN
      if (stub_never || lat > TMO) begin
        m_resp_at = cyc + TMO + 1; m_err = 1; m_sin = 0; m_cos = 0;
      end else begin
        m_resp_at = cyc + lat + 1; m_err = 0; m_sin = core_sin; m_cos = core_cos;
      end
`else
      m_resp_at = stub_never ? NEVER : cyc + lat + 1;
      m_err = 0; m_sin = core_sin; m_cos = core_cos;
`endif
    end
    chk("resp_vld", 32'(resp_vld), 32'(cyc == m_resp_at));
    if (resp_vld) begin
      last_resp_cyc = cyc; last_resp_id = int'(resp_id);
      last_resp_sin = resp_sin; last_resp_cos = resp_cos; last_resp_err = resp_err;
    end
    if (cyc == m_resp_at) begin
      chk("resp_id",  32'(resp_id),  32'(m_id));
      chk("resp_sin", 32'(resp_sin), 32'(m_sin));
      chk("resp_cos", 32'(resp_cos), 32'(m_cos));
      chk("resp_err", 32'(resp_err), 32'(m_err));
      m_busy = 0;
    end
  endtask

  task automatic step();
    bit v;
    @(posedge sys_clk); #1;
    cyc++;
    req_vld = drv_vld; req_phase = drv_phase;
    v = (cyc == core_at) || (cyc == spur_at);
    if (spur_en && (!m_busy || cyc <= m_trig_at || cyc >= m_resp_at) && $urandom_range(7, 0) == 0)
      v = 1;
    cor_vld = v;
    if (cyc == core_at) begin
      cor_sin = core_sin; cor_cos = core_cos;
    end else begin
      cor_sin = 13'($urandom); cor_cos = 13'($urandom);
    end
    @(negedge sys_clk);
    check_cycle();
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b1; #1;
    chk("rst_req_rdy",  32'(req_rdy),  0);
    chk("rst_cor_trig", 32'(cor_trig), 0);
    chk("rst_cor_data", 32'(cor_data), 0);
    chk("rst_resp_vld", 32'(resp_vld), 0);
    chk("rst_resp_id",  32'(resp_id),  0);
    chk("rst_resp_sin", 32'(resp_sin), 0);
    chk("rst_resp_cos", 32'(resp_cos), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    cor_vld = 0;
    repeat (2) begin
      @(posedge sys_clk); #1;
      chk("rst_hold_resp_vld", 32'(resp_vld), 0);
    end
    #2 sys_rst_n = 1'b0;
    model_reset();
    grant_log.delete(); gcyc_log.delete();
  endtask

  task automatic wait_grants(input int n, input int budget);
    int b = 0;
    while (grant_log.size() < n && b < budget) begin step(); b++; end
    chk("grant_wait", 32'(grant_log.size() >= n), 1);
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while (m_busy && b < budget) begin step(); b++; end
    chk("idle_wait", 32'(m_busy), 0);
  endtask

  initial begin
    bit pend[N];
    req_vld = '0; req_phase = '0; cor_vld = 0; cor_sin = 0; cor_cos = 0;
    model_reset();
    do_reset();

    // single request: requester 2, phase 256, L=14
    stub_lat = 14; stub_fix = 1; fix_sin = 13'sd2048; fix_cos = 13'sd0;
    drv_phase = '0; drv_phase[20 +: 10] = 10'd256; drv_vld = 4'b0100;
    wait_grants(1, 20);
    drv_vld = '0;
    wait_idle(100);
    chk("single_trig_lat", 32'(last_trig_cyc - gcyc_log[0]), 1);
    chk("single_resp_lat", 32'(last_resp_cyc - gcyc_log[0]), 16);
    chk("single_id",  32'(last_resp_id), 2);
    chk("single_sin", 32'(last_resp_sin), 32'(13'sd2048));
    chk("single_cos", 32'(last_resp_cos), 0);
    chk("single_err", 32'(last_resp_err), 0);

    // fairness: all four held from reset, L=5
    do_reset();
    stub_lat = 5; stub_fix = 0;
    for (int k = 0; k < N; k++) drv_phase[k*10 +: 10] = 10'(100 + k);
    drv_vld = 4'b1111;
    wait_grants(5, 200);
    drv_vld = '0;
    wait_idle(50);
    if (grant_log.size() >= 5) begin
      chk("fair_g0", 32'(grant_log[0]), 0);
      chk("fair_g1", 32'(grant_log[1]), 1);
      chk("fair_g2", 32'(grant_log[2]), 2);
      chk("fair_g3", 32'(grant_log[3]), 3);
      chk("fair_g4", 32'(grant_log[4]), 0);
      chk("fair_period", 32'(gcyc_log[1] - gcyc_log[0]), 8);
    end

    // withdraw and skip: ptr=1, requester 0 withdraws, 1 and 3 active
    do_reset();
    stub_lat = 10;
    drv_vld = 4'b0010;
    wait_grants(1, 20);
    drv_vld = 4'b1011;
    repeat (3) step();
    drv_vld = 4'b1010;
    wait_grants(3, 100);
    drv_vld = '0;
    wait_idle(50);
    if (grant_log.size() >= 3) begin
      chk("skip_g0", 32'(grant_log[0]), 1);
      chk("skip_g1", 32'(grant_log[1]), 3);
      chk("skip_g2", 32'(grant_log[2]), 1);
    end

`ifdef SINCOS_ARB_TIMEOUT_EN
    // timeout: core never answers, then a late valid
    do_reset();
    stub_never = 1;
    drv_phase[0 +: 10] = 10'd77; drv_vld = 4'b0001;
    wait_grants(1, 20);
    drv_vld = '0;
    wait_idle(150);
    stub_never = 0;
    chk("tmo_lat", 32'(last_resp_cyc - last_trig_cyc), 101);
    chk("tmo_err", 32'(last_resp_err), 1);
    chk("tmo_sin", 32'(last_resp_sin), 0);
    spur_at = cyc + 5;
    repeat (10) step();

    // tie: valid exactly on the terminal count
    stub_lat = TMO; stub_fix = 1; fix_sin = -13'sd1234; fix_cos = 13'sd555;
    drv_vld = 4'b0010;
    wait_grants(1, 20);
    drv_vld = '0;
    wait_idle(150);
    chk("tie_lat", 32'(last_resp_cyc - last_trig_cyc), 101);
    chk("tie_err", 32'(last_resp_err), 0);
    chk("tie_sin", 32'(last_resp_sin), 32'(-13'sd1234));
    stub_fix = 0;
`endif

    // randomized traffic with stray core valids outside WAIT
    do_reset();
    stub_lat = 0; spur_en = 1;
    drv_vld = '0;
    for (int k = 0; k < N; k++) pend[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (pend[k] && seen_rdy[k]) pend[k] = 0;
        else if (pend[k] && $urandom_range(31, 0) == 0) pend[k] = 0;
        else if (!pend[k] && $urandom_range(3, 0) == 0) begin
          pend[k] = 1;
          drv_phase[k*10 +: 10] = 10'($urandom);
        end
        drv_vld[k] = pend[k];
      end
      step();
    end
    drv_vld = '0; spur_en = 0;
    wait_idle(100);

    // reset while in WAIT: no response, late valid ignored, requester 0 first after
    stub_lat = 20;
    drv_phase[20 +: 10] = 10'd300; drv_vld = 4'b0100;
    wait_grants(1, 20);
    drv_vld = '0;
    repeat (5) step();
    do_reset();
    spur_at = cyc + 2;
    repeat (4) step();
    drv_vld = 4'b1111;
    wait_grants(1, 20);
    drv_vld = '0;
    wait_idle(50);
    if (grant_log.size() >= 1) chk("post_rst_first", 32'(grant_log[0]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
